// File: rtl/hwag_pkg.sv
// Shared types and field widths for the HWAG output channels.
// Both the ignition channel and the angle-wrap helper import this package.
package hwag_pkg;

  localparam int ANG_W = 24;
  localparam int TMR_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CHARGE,
    HOLDOFF
  } ign_state_t;

endpackage

// File: rtl/hwag_angle_wrap_sub.sv
// Combinational modular subtraction: start angle = (ang - dlt) wrapped into 0..max.
// The delta is clamped to one full cycle so an oversize dwell never wraps twice.
module hwag_angle_wrap_sub
  import hwag_pkg::*;
#(
  parameter int AW = ANG_W
) (
  input  logic [AW-1:0] i_ang,
  input  logic [AW-1:0] i_dlt,
  input  logic [AW-1:0] i_max,
  output logic [AW-1:0] o_set_ang
);

  logic [AW:0] w_ang;
  logic [AW:0] w_dlt;
  logic [AW:0] w_max;
  logic [AW:0] w_dlt_s;

  always_comb begin
    w_ang   = {1'b0, i_ang};
    w_dlt   = {1'b0, i_dlt};
    w_max   = {1'b0, i_max};
    w_dlt_s = (w_dlt > w_max) ? w_max : w_dlt;
    // One extra bit keeps ang + max + 1 from overflowing before truncation.
    if (w_ang >= w_dlt_s) begin
      o_set_ang = AW'(w_ang - w_dlt_s);
    end else begin
      o_set_ang = AW'(w_ang + w_max + {{AW{1'b0}}, 1'b1} - w_dlt_s);
    end
  end

endmodule

// File: rtl/hwag_ign_channel.sv
// One ignition coil channel: charges from (angle - dwell) to angle on the HWAG count,
// with double-buffered CPU parameters and an over-dwell cut-off timer.
module hwag_ign_channel
  import hwag_pkg::*;
#(
  parameter int AW = ANG_W,
  parameter int TW = TMR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          hwag_start,
  input  logic [AW-1:0] acnt,
  input  logic [AW-1:0] acnt_max,
  input  logic [AW-1:0] din,
  input  logic          wr_ang,
  input  logic          wr_dlt,
  input  logic [TW-1:0] chrg_max,
  output logic          ign_out,
  output logic          spark_stb,
  output logic          ovd_stb,
  output logic          busy,
  output logic [AW-1:0] set_ang
);

  ign_state_t r_state;
  ign_state_t w_state_nxt;

  logic [AW-1:0] r_sh_ang;
  logic [AW-1:0] r_sh_dlt;
  logic [AW-1:0] r_act_ang;
  logic [AW-1:0] r_act_dlt;
  logic [AW-1:0] r_set_ang;
  logic [TW-1:0] r_timer;
  logic          r_ign;
  logic          r_spark;
  logic          r_ovd;

  logic [AW-1:0] w_wrap_ang;
  logic [TW:0]   w_timer_inc;
  logic [TW-1:0] w_timer_nxt;
  logic          w_commit;
  logic          w_ign_nxt;
  logic          w_spark_nxt;
  logic          w_ovd_nxt;

  // The start angle is computed from the shadow pair, since those become active on commit.
  hwag_angle_wrap_sub #(
    .AW(AW)
  ) u_wrap (
    .i_ang    (r_sh_ang),
    .i_dlt    (r_sh_dlt),
    .i_max    (acnt_max),
    .o_set_ang(w_wrap_ang)
  );

  assign w_timer_inc = {1'b0, r_timer} + {{TW{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_ign_nxt   = r_ign;
    w_spark_nxt = 1'b0;
    w_ovd_nxt   = 1'b0;
    w_timer_nxt = r_timer;
    if (!(ena && hwag_start)) begin
      w_state_nxt = IDLE;
      w_ign_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_ign_nxt   = 1'b0;
          w_state_nxt = ARMED;
          w_commit    = 1'b1;
        end
        ARMED: begin
          w_ign_nxt = 1'b0;
          if (acnt == r_set_ang) begin
            if (r_act_dlt != '0) begin
              w_state_nxt = CHARGE;
              w_ign_nxt   = 1'b1;
              w_timer_nxt = '0;
            end
          end else begin
            w_commit = 1'b1;
          end
        end
        CHARGE: begin
          w_timer_nxt = (&r_timer) ? r_timer : w_timer_inc[TW-1:0];
          // A spark on the same cycle as the over-dwell limit wins.
          if (acnt == r_act_ang) begin
            w_ign_nxt   = 1'b0;
            w_spark_nxt = 1'b1;
            w_state_nxt = ARMED;
            w_commit    = 1'b1;
          end else if ((chrg_max != '0) && (w_timer_inc >= {1'b0, chrg_max})) begin
            w_ign_nxt   = 1'b0;
            w_ovd_nxt   = 1'b1;
            w_state_nxt = HOLDOFF;
          end
        end
        HOLDOFF: begin
          w_ign_nxt = 1'b0;
          if (acnt == r_act_ang) begin
            w_state_nxt = ARMED;
            w_commit    = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_ign_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ign   <= 1'b0;
      r_spark <= 1'b0;
      r_ovd   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ign   <= w_ign_nxt;
      r_spark <= w_spark_nxt;
      r_ovd   <= w_ovd_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Commit reads the shadows before this cycle's CPU write lands in them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_ang  <= '0;
      r_sh_dlt  <= '0;
      r_act_ang <= '0;
      r_act_dlt <= '0;
      r_set_ang <= '0;
    end else begin
      if (w_commit) begin
        r_act_ang <= r_sh_ang;
        r_act_dlt <= r_sh_dlt;
        r_set_ang <= w_wrap_ang;
      end
      if (wr_ang) begin
        r_sh_ang <= din;
      end
      if (wr_dlt) begin
        r_sh_dlt <= din;
      end
    end
  end

  assign ign_out   = r_ign;
  assign spark_stb = r_spark;
  assign ovd_stb   = r_ovd;
  assign busy      = (r_state != IDLE);
  assign set_ang   = r_set_ang;

endmodule

// File: doc/hwag_ign_channel.md
Name: hwag_ign_channel

Overview:
- One ignition output channel downstream of the HWAG angle engine.
- Consumes the fine angle count (acnt2 domain), the angle wrap limit (HWAMAXACR), the hwag_start status, and a dwell delta angle already converted from charge time.
- Drives one coil output: charge starts at (ignition angle − dwell delta) modulo the cycle length; the spark occurs at the ignition angle.
- Double-buffers CPU-written parameters, guards against over-dwell, and emits event strobes for the interrupt flag register.

Parameters:
- AW, 24, width of angle count, angles and delta.
- TW, 24, width of the over-dwell cycle timer and limit.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high; clears every register in the block.
- ena  in  1  channel enable (control register bit).
- hwag_start  in  1  angle engine synchronised; low means the angle count is invalid.
- acnt  in  AW  current angle count; steps by at most 1 per clk; wraps from acnt_max to 0.
- acnt_max  in  AW  last valid angle value (HWAMAXACR).
- din  in  AW  CPU write data for the shadow registers.
- wr_ang  in  1  one-cycle strobe: shadow ignition angle <= din.
- wr_dlt  in  1  one-cycle strobe: shadow dwell delta <= din.
- chrg_max  in  TW  over-dwell limit in clk cycles; 0 disables the guard.
- ign_out  out  1  coil drive, registered, 1 = charging.
- spark_stb  out  1  one-cycle pulse on a normal spark (falling ign_out at the ignition angle).
- ovd_stb  out  1  one-cycle pulse on an over-dwell forced cut.
- busy  out  1  state is not IDLE.
- set_ang  out  AW  active charge-start angle, for readback.

Behaviour:
- Reset values: ign_out=0, spark_stb=0, ovd_stb=0, busy=0, set_ang=0. Shadow and active registers are 0. State is IDLE.
- Shadow regs sh_ang and sh_dlt are written on their strobes in any state. If both strobes are active in the same cycle, both registers load din.
- Commit copies the shadow regs into the active regs act_ang and act_dlt, and registers set_ang. Commit uses the shadow contents before any same-cycle write; a same-cycle write lands at the next commit.
- set_ang computation:
  - dlt_s = min(act_dlt, acnt_max).
  - If act_ang >= dlt_s: set_ang = act_ang − dlt_s.
  - Otherwise: set_ang = act_ang + acnt_max + 1 − dlt_s.
  - All arithmetic is done at AW+1 bits; the result is truncated to AW.
- Commit points:
  - The IDLE->ARMED transition.
  - Every exit from CHARGE or HOLDOFF back to ARMED.
  - Every cycle spent in ARMED while acnt != set_ang.
- FSM, one transition per clk, outputs registered:
  - IDLE: ign_out=0. Go to ARMED (with commit) when ena & hwag_start.
  - ARMED, on acnt == set_ang:
    - If act_dlt != 0, go to CHARGE, ign_out<=1, timer<=0.
    - If act_dlt == 0, stay in ARMED; no pulse and no strobe.
  - CHARGE: timer increments and saturates at all ones.
    - If acnt == act_ang: ign_out<=0, spark_stb<=1, go to ARMED (commit).
    - Else if chrg_max != 0 and timer+1 >= chrg_max: ign_out<=0, ovd_stb<=1, go to HOLDOFF.
    - If both conditions hold in the same cycle, the spark takes priority.
  - HOLDOFF: ign_out=0. When acnt == act_ang, go to ARMED (commit) with no spark_stb. This prevents a late re-charge within the same cycle.
- Abort: if ena=0 or hwag_start=0 in any state, the next state is IDLE and ign_out<=0 on that edge. No strobe is issued.
- Latency:
  - ign_out rises on the clk edge at which acnt==set_ang is sampled in ARMED.
  - ign_out falls on the edge at which acnt==act_ang is sampled in CHARGE.
- Parameters changed while in CHARGE do not move the pending spark; they affect the following event only.
- The strobes are high for exactly one cycle.

Decomposition:
- Package hwag_pkg:
  - typedef enum ign_state_t {IDLE, ARMED, CHARGE, HOLDOFF}.
  - Localparam widths for the angle (24) and timer (24) fields.
- Sub-module hwag_angle_wrap_sub: combinational modular subtraction (ang, dlt, max -> set_ang). It is reused later by the injection channel.
- The FSM, shadow/active registers and timer live in the top module.

Test Plan:
1. acnt_max=3599, ang=1000, dlt=200; acnt ramps 0..3599 one step per 4 clk -> ign_out rises on the acnt==800 edge, falls on the acnt==1000 edge; spark_stb is a single pulse; set_ang=800.
2. Wrap: ang=100, dlt=300 -> set_ang=3400; ign_out is high from acnt 3400 through the wrap to acnt 100, then spark_stb.
3. Over-dwell: ang=1000, dlt=200, chrg_max=50; acnt held at 900 -> ign_out falls after 50 cycles in CHARGE; ovd_stb=1; state HOLDOFF; releasing acnt to 1000 -> ARMED with no spark_stb.
4. Shadow update: in CHARGE (ang=1000), write ang=2000 -> spark still at 1000; then set_ang=1800 and the next pulse spans 1800..2000.
5. Abort: drop hwag_start mid-CHARGE -> ign_out=0 next edge, IDLE, busy=0, no strobes; assert rst mid-CHARGE -> ign_out=0 immediately (asynchronous).
6. dlt=0 with ang=500 -> no ign_out pulse and no strobes over a full revolution; dlt=5000 (>acnt_max=3599) -> clamped to 3599, set_ang=(500+3600−3599)=501.
